// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//
// Iterative rotation-mode CORDIC. One micro-rotation per enabled clock, so an
// operation takes CORD_ITER iterations plus a one-cycle DONE state. All data is
// signed 1.1.22 fixed point (1.0 = 24'h400000).
//
// Parameters
//   CORD_ITER  micro-rotations per operation (1..16)
//   K_INIT     initial x, the CORDIC gain compensation (0.607253 by default)
//
// Ports
//   clk        single clock
//   reset_n    asynchronous active-low reset
//   clk_en     clock enable; when low all state and outputs hold
//   start      begin an operation (sampled only in IDLE)
//   angle      signed angle in radians, clamped to [-pi/2, +pi/2]
//   cos_out    cosine result, valid from done until the next done
//   sin_out    sine result, valid from done until the next done
//   busy       high from the load edge until the end of the DONE cycle
//   done       one enabled-cycle pulse marking new results
//   range_err  1 if the last loaded angle was clamped
// -----------------------------------------------------------------------------
module cordic_iter_ctrl #(
   parameter int unsigned CORD_ITER = 16,
   parameter logic [23:0] K_INIT    = 24'h26DD3B
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clk_en,
   input  logic               start,
   input  logic signed [23:0] angle,
   output logic signed [23:0] cos_out,
   output logic signed [23:0] sin_out,
   output logic               busy,
   output logic               done,
   output logic               range_err
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StIter = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic signed [23:0] HalfPi    = 24'sh6487ED;
   localparam logic signed [23:0] NegHalfPi = -24'sh6487ED;
   localparam logic [3:0]         LastCnt   = 4'(CORD_ITER - 1);

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [23:0] x_q, x_d;
   logic signed [23:0] y_q, y_d;
   logic signed [23:0] z_q, z_d;
   logic signed [23:0] cos_q, cos_d;
   logic signed [23:0] sin_q, sin_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               range_err_q, range_err_d;

   logic signed [23:0] angle_clamped;
   logic               clamped;
   logic signed [23:0] atan_i;
   logic signed [23:0] x_shr, y_shr;
   logic signed [23:0] x_new, y_new, z_new;

   // atan(2^-i) in 1.1.22
   function automatic logic signed [23:0] atan_lut(input logic [3:0] i);
      logic signed [23:0] v;
      case (i)
         4'd0:    v = 24'sh3243F6;
         4'd1:    v = 24'sh1DAC67;
         4'd2:    v = 24'sh0FADBA;
         4'd3:    v = 24'sh07F56E;
         4'd4:    v = 24'sh03FEAB;
         4'd5:    v = 24'sh01FFD5;
         4'd6:    v = 24'sh00FFFA;
         4'd7:    v = 24'sh007FFF;
         4'd8:    v = 24'sh003FFF;
         4'd9:    v = 24'sh001FFF;
         4'd10:   v = 24'sh000FFF;
         4'd11:   v = 24'sh0007FF;
         4'd12:   v = 24'sh0003FF;
         4'd13:   v = 24'sh0001FF;
         4'd14:   v = 24'sh0000FF;
         default: v = 24'sh00007F;
      endcase
      return v;
   endfunction

   // Rotation mode only converges inside +/-pi/2, so saturate the request there
   always_comb begin
      angle_clamped = angle;
      clamped       = 1'b0;
      if (angle > HalfPi) begin
         angle_clamped = HalfPi;
         clamped       = 1'b1;
      end else if (angle < NegHalfPi) begin
         angle_clamped = NegHalfPi;
         clamped       = 1'b1;
      end
   end

   // One micro-rotation; direction follows the sign of the residual angle
   always_comb begin
      atan_i = atan_lut(cnt_q);
      x_shr  = x_q >>> cnt_q;
      y_shr  = y_q >>> cnt_q;
      if (!z_q[23]) begin
         x_new = x_q - y_shr;
         y_new = y_q + x_shr;
         z_new = z_q - atan_i;
      end else begin
         x_new = x_q + y_shr;
         y_new = y_q - x_shr;
         z_new = z_q + atan_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      cos_d       = cos_q;
      sin_d       = sin_q;
      busy_d      = busy_q;
      done_d      = done_q;
      range_err_d = range_err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StIter;
               cnt_d       = 4'd0;
               x_d         = K_INIT;
               y_d         = 24'sd0;
               z_d         = angle_clamped;
               busy_d      = 1'b1;
               range_err_d = clamped;
            end
         end
         StIter: begin
            x_d = x_new;
            y_d = y_new;
            z_d = z_new;
            if (cnt_q == LastCnt) begin
               cos_d   = x_new;
               sin_d   = y_new;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         x_q         <= 24'sd0;
         y_q         <= 24'sd0;
         z_q         <= 24'sd0;
         cos_q       <= 24'sd0;
         sin_q       <= 24'sd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else if (clk_en) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         cos_q       <= cos_d;
         sin_q       <= sin_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         range_err_q <= range_err_d;
      end
   end

   assign cos_out   = cos_q;
   assign sin_out   = sin_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_ctrl
//
// Scenario bench for cordic_iter_ctrl. Expected results come from a reference
// CORDIC model and are queued when an operation is issued, then popped and
// compared when done is seen. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_cordic_iter_ctrl;

   localparam logic signed [23:0] HalfPi = 24'sh6487ED;
   localparam logic signed [23:0] AtanTab [16] = '{
      24'sh3243F6, 24'sh1DAC67, 24'sh0FADBA, 24'sh07F56E,
      24'sh03FEAB, 24'sh01FFD5, 24'sh00FFFA, 24'sh007FFF,
      24'sh003FFF, 24'sh001FFF, 24'sh000FFF, 24'sh0007FF,
      24'sh0003FF, 24'sh0001FF, 24'sh0000FF, 24'sh00007F
   };
   localparam int Tol = 256;

   logic               clk;
   logic               reset_n;
   logic               clk_en;
   logic               start;
   logic signed [23:0] angle;
   logic signed [23:0] cos_out;
   logic signed [23:0] sin_out;
   logic               busy;
   logic               done;
   logic               range_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic signed [23:0] sb_cos [$];
   logic signed [23:0] sb_sin [$];
   logic               sb_rerr [$];

   cordic_iter_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clk_en    (clk_en),
      .start     (start),
      .angle     (angle),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .busy      (busy),
      .done      (done),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference CORDIC: clamp, then 16 rotation-mode micro-rotations
   function automatic void model(input logic signed [23:0] a, output logic signed [23:0] c,
                                 output logic signed [23:0] s, output logic re);
      logic signed [23:0] x, y, z, xn, yn;
      re = 1'b0;
      z  = a;
      if (a > HalfPi) begin
         z  = HalfPi;
         re = 1'b1;
      end else if (a < -HalfPi) begin
         z  = -HalfPi;
         re = 1'b1;
      end
      x = 24'sh26DD3B;
      y = 24'sd0;
      for (int i = 0; i < 16; i++) begin
         if (z[23] == 1'b0) begin
            xn = x - (y >>> i);
            yn = y + (x >>> i);
            z  = z - AtanTab[i];
         end else begin
            xn = x + (y >>> i);
            yn = y - (x >>> i);
            z  = z + AtanTab[i];
         end
         x = xn;
         y = yn;
      end
      c = x;
      s = y;
   endfunction

   function automatic int sdist(input logic signed [23:0] a, input logic signed [23:0] b);
      int d;
      d = int'(a) - int'(b);
      return (d < 0) ? -d : d;
   endfunction

   function automatic void push_exp(input logic signed [23:0] a);
      logic signed [23:0] c, s;
      logic               re;
      model(a, c, s, re);
      sb_cos.push_back(c);
      sb_sin.push_back(s);
      sb_rerr.push_back(re);
   endfunction

   // Issue one operation and count falling edges until done (-1 on timeout)
   task automatic run_op(input logic signed [23:0] a, output int lat);
      push_exp(a);
      @(negedge clk);
      angle = a;
      start = 1'b1;
      lat   = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clk_en  = 1'b1;
      start   = 1'b0;
      angle   = 24'sd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (cos_out !== 24'sd0 || sin_out !== 24'sd0)
         $display("FAIL reset_data: cos=%h sin=%h required=000000/000000", cos_out, sin_out);
      else n_pass++;
      n_checks++;
      if ({busy, done, range_err} !== 3'b000)
         $display("FAIL reset_flags: busy/done/rerr=%b required=000", {busy, done, range_err});
      else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_zero();
      int lat;
      logic signed [23:0] ec, es;
      logic               er;
      run_op(24'sd0, lat);
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      n_checks++;
      if (lat !== 17) $display("FAIL zero_latency: got=%0d required=17", lat);
      else n_pass++;
      n_checks++;
      if (cos_out !== ec || sin_out !== es || range_err !== er)
         $display("FAIL zero_exact: cos=%h sin=%h rerr=%b required=%h %h %b",
                  cos_out, sin_out, range_err, ec, es, er);
      else n_pass++;
      n_checks++;
      if (sdist(cos_out, 24'sh400000) > Tol || sdist(sin_out, 24'sd0) > Tol || range_err !== 1'b0)
         $display("FAIL zero_tol: cos=%h sin=%h rerr=%b required=400000 000000 0",
                  cos_out, sin_out, range_err);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL zero_pulse: done=%b busy=%b required=0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_pi4();
      int lat;
      logic signed [23:0] ec, es;
      logic               er;
      run_op(24'sh3243F6, lat);
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      n_checks++;
      if (lat !== 17 || cos_out !== ec || sin_out !== es || range_err !== er)
         $display("FAIL pi4_exact: lat=%0d cos=%h sin=%h rerr=%b required=17 %h %h %b",
                  lat, cos_out, sin_out, range_err, ec, es, er);
      else n_pass++;
      n_checks++;
      if (sdist(cos_out, 24'sh2D413C) > Tol || sdist(sin_out, 24'sh2D413C) > Tol)
         $display("FAIL pi4_tol: cos=%h sin=%h required=2D413C 2D413C", cos_out, sin_out);
      else n_pass++;
   endtask

   task automatic test_clamp();
      int lat;
      logic signed [23:0] ec, es;
      logic               er;
      logic signed [23:0] angles [6] = '{24'sh700000, 24'sh900000, 24'sh6487ED,
                                         24'sh6487EE, 24'sh9B7813, 24'sh9B7812};
      logic               rerr_req [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 6; t++) begin
         run_op(angles[t], lat);
         ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
         n_checks++;
         if (lat !== 17 || cos_out !== ec || sin_out !== es || range_err !== er)
            $display("FAIL clamp_exact[%0d]: lat=%0d cos=%h sin=%h rerr=%b required=17 %h %h %b",
                     t, lat, cos_out, sin_out, range_err, ec, es, er);
         else n_pass++;
         n_checks++;
         if (range_err !== rerr_req[t])
            $display("FAIL clamp_rerr[%0d]: got=%b required=%b", t, range_err, rerr_req[t]);
         else n_pass++;
         if (t == 0) begin
            n_checks++;
            if (sdist(cos_out, 24'sd0) > Tol || sdist(sin_out, 24'sh400000) > Tol)
               $display("FAIL clamp_pos_tol: cos=%h sin=%h required=000000 400000",
                        cos_out, sin_out);
            else n_pass++;
         end
         if (t == 1) begin
            n_checks++;
            if (sdist(sin_out, 24'shC00000) > Tol)
               $display("FAIL clamp_neg_tol: sin=%h required=C00000", sin_out);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int done_at [$];
      int gaps;
      logic signed [23:0] ec, es;
      logic               er;
      int lat;
      gaps = 0;
      repeat (3) push_exp(24'sh7FFFFF);
      @(negedge clk);
      angle = 24'sh7FFFFF;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if ((k <= 17 || (k >= 19 && k <= 35)) && busy !== 1'b1) gaps++;
         if (done) begin
            done_at.push_back(k);
            ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
            n_checks++;
            if (cos_out !== ec || sin_out !== es || range_err !== er)
               $display("FAIL b2b_exact@%0d: cos=%h sin=%h rerr=%b required=%h %h %b",
                        k, cos_out, sin_out, range_err, ec, es, er);
            else n_pass++;
         end
      end
      start = 1'b0;
      n_checks++;
      if (done_at.size() != 2 || done_at[0] != 17 || done_at[1] != 35)
         $display("FAIL b2b_spacing: count=%0d first=%0d second=%0d required=2 17 35",
                  done_at.size(), (done_at.size() > 0) ? done_at[0] : -1,
                  (done_at.size() > 1) ? done_at[1] : -1);
      else n_pass++;
      n_checks++;
      if (gaps != 0) $display("FAIL b2b_busy: low_cycles=%0d required=0", gaps);
      else n_pass++;
      // Third operation was loaded while start was still held; drain it
      lat = -1;
      for (int k = 41; k <= 80; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      n_checks++;
      if (lat !== 53 || cos_out !== ec || sin_out !== es || range_err !== er)
         $display("FAIL b2b_third: at=%0d cos=%h sin=%h rerr=%b required=53 %h %h %b",
                  lat, cos_out, sin_out, range_err, ec, es, er);
      else n_pass++;
   endtask

   task automatic test_abort();
      int lat;
      int spurious;
      logic signed [23:0] ec, es;
      logic               er;
      spurious = 0;
      @(negedge clk);
      angle = 24'sh123456;
      start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b1 || cos_out === 24'sd0)
         $display("FAIL abort_pre: busy=%b cos=%h required=1 nonzero", busy, cos_out);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (cos_out !== 24'sd0 || sin_out !== 24'sd0 ||
          {busy, done, range_err} !== 3'b000)
         $display("FAIL abort_clear: cos=%h sin=%h busy/done/rerr=%b required=0 0 000",
                  cos_out, sin_out, {busy, done, range_err});
      else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (done) spurious++;
      end
      // Leave reset and issue start together
      push_exp(-24'sh3243F6);
      reset_n = 1'b1;
      angle   = -24'sh3243F6;
      start   = 1'b1;
      lat     = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      n_checks++;
      if (spurious != 0 || lat !== 17)
         $display("FAIL abort_restart: spurious=%0d lat=%0d required=0 17", spurious, lat);
      else n_pass++;
      n_checks++;
      if (cos_out !== ec || sin_out !== es || range_err !== er ||
          sdist(sin_out, 24'shD2BEC4) > Tol)
         $display("FAIL abort_result: cos=%h sin=%h rerr=%b required=%h %h(~D2BEC4) %b",
                  cos_out, sin_out, range_err, ec, es, er);
      else n_pass++;
   endtask

   task automatic test_stall();
      int lat;
      int held;
      logic signed [23:0] ref_c, ref_s;
      logic signed [23:0] ec, es;
      logic               er;
      run_op(24'sh1A2B3C, lat);
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      ref_c = cos_out;
      ref_s = sin_out;
      n_checks++;
      if (lat !== 17 || ref_c !== ec || ref_s !== es || range_err !== er)
         $display("FAIL stall_ref: lat=%0d cos=%h sin=%h required=17 %h %h",
                  lat, ref_c, ref_s, ec, es);
      else n_pass++;
      @(negedge clk);
      push_exp(24'sh1A2B3C);
      @(negedge clk);
      angle = 24'sh1A2B3C;
      start = 1'b1;
      lat   = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 5) clk_en = 1'b0;
         if (k == 10) clk_en = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
      end
      n_checks++;
      if (lat !== 22) $display("FAIL stall_latency: got=%0d required=22", lat);
      else n_pass++;
      clk_en = 1'b0;
      held   = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1 && busy === 1'b1) held++;
      end
      clk_en = 1'b1;
      n_checks++;
      if (held != 3) $display("FAIL stall_done_hold: cycles=%0d required=3", held);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL stall_done_end: done=%b busy=%b required=0 0", done, busy);
      else n_pass++;
      ec = sb_cos.pop_front(); es = sb_sin.pop_front(); er = sb_rerr.pop_front();
      n_checks++;
      if (cos_out !== ref_c || sin_out !== ref_s || cos_out !== ec || sin_out !== es)
         $display("FAIL stall_result: cos=%h sin=%h required=%h %h", cos_out, sin_out, ec, es);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_zero();
      test_pi4();
      test_back_to_back();
      test_abort();
      test_clamp();
      test_stall();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
